// File: rtl/i2s_frame_arbiter.sv
// ============================================================================
//  Module   : i2s_frame_arbiter
//  Purpose  : Round-robin admission of two stereo producers into a frame FIFO,
//             one frame popped and held per transmitter frame request.
//             Optional I2S_FRAME_ARB_HOLD_LAST_EN: repeat last frame on underrun.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module i2s_frame_arbiter #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s0_valid,
    output logic          s0_ready,
    input  logic [DW-1:0] s0_left,
    input  logic [DW-1:0] s0_right,
    input  logic          s1_valid,
    output logic          s1_ready,
    input  logic [DW-1:0] s1_left,
    input  logic [DW-1:0] s1_right,
    input  logic          frame_req,
    input  logic          flush,
    input  logic          mute,
    output logic [DW-1:0] left_data,
    output logic [DW-1:0] right_data,
    output logic          frame_valid,
    output logic          frame_src,
    output logic [AW:0]   fifo_level,
    output logic [15:0]   underrun_cnt
);

    localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
    localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);

    logic [DW-1:0] mem_l_q [DEPTH];
    logic [DW-1:0] mem_r_q [DEPTH];
    logic          mem_s_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          rr_last_q;
    logic [DW-1:0] left_q, right_q;
    logic          fvalid_q, fsrc_q;
    logic [15:0]   ucnt_q;

    logic          w_full, w_can_push, w_grant0, w_grant1, w_push, w_pop, w_underrun;
    logic [DW-1:0] w_push_l, w_push_r;

    // Ties go to whichever producer was not granted last.
    always_comb begin
        w_full     = (count_q == C_DEPTH);
        w_can_push = !w_full && !flush;
        w_grant0   = w_can_push && s0_valid && (!s1_valid || rr_last_q);
        w_grant1   = w_can_push && s1_valid && (!s0_valid || !rr_last_q);
        w_push     = w_grant0 || w_grant1;
        w_push_l   = w_grant1 ? s1_left  : s0_left;
        w_push_r   = w_grant1 ? s1_right : s0_right;
        w_pop      = frame_req && !flush && (count_q != '0);
        w_underrun = frame_req && !w_pop;
        count_d    = count_q;
        if (w_push && !w_pop)
            count_d = count_q + C_CNT_ONE;
        else if (w_pop && !w_push)
            count_d = count_q - C_CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_l_q[wr_ptr_q] <= w_push_l;
            mem_r_q[wr_ptr_q] <= w_push_r;
            mem_s_q[wr_ptr_q] <= w_grant1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rr_last_q <= 1'b1;
            left_q    <= '0;
            right_q   <= '0;
            fvalid_q  <= 1'b0;
            fsrc_q    <= 1'b0;
            ucnt_q    <= '0;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                count_q <= count_d;
                if (w_push)
                    wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
                if (w_pop)
                    rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
            end
            if (w_push)
                rr_last_q <= w_grant1;
            if (w_pop) begin
                left_q   <= mute ? '0 : mem_l_q[rd_ptr_q];
                right_q  <= mute ? '0 : mem_r_q[rd_ptr_q];
                fvalid_q <= 1'b1;
                fsrc_q   <= mem_s_q[rd_ptr_q];
            end else if (w_underrun) begin
`ifdef I2S_FRAME_ARB_HOLD_LAST_EN
                left_q   <= left_q;
                right_q  <= right_q;
`else
                left_q   <= '0;
                right_q  <= '0;
`endif
                fvalid_q <= 1'b0;
                if (ucnt_q != 16'hFFFF)
                    ucnt_q <= ucnt_q + 16'd1;
            end
        end
    end

    assign s0_ready     = w_grant0;
    assign s1_ready     = w_grant1;
    assign left_data    = left_q;
    assign right_data   = right_q;
    assign frame_valid  = fvalid_q;
    assign frame_src    = fsrc_q;
    assign fifo_level   = count_q;
    assign underrun_cnt = ucnt_q;

endmodule

`default_nettype wire

// File: doc/i2s_frame_arbiter.md
Name: i2s_frame_arbiter

Overview:
- Sequences stereo audio frames into the I2S transmitter's parallel inputs.
- Two sample producers share the transmitter. A round-robin arbiter admits their stereo frames into a small FIFO.
- On each frame request from the transmitter side, one frame is popped and held stable on left_data/right_data for the whole I2S frame.
- Underruns are handled deterministically and counted.

Parameters:
- DW, 16, audio sample width per channel (transmitter datapath width).
- DEPTH, 4, FIFO depth in stereo frames; power of 2, at least 2.
- AW, 2, FIFO address width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- s0_valid  input  1  producer 0 has a stereo frame
- s0_ready  output  1  producer 0 frame accepted this cycle (when valid)
- s0_left  input  DW  producer 0 left sample
- s0_right  input  DW  producer 0 right sample
- s1_valid  input  1  producer 1 has a stereo frame
- s1_ready  output  1  producer 1 frame accepted this cycle (when valid)
- s1_left  input  DW  producer 1 left sample
- s1_right  input  DW  producer 1 right sample
- frame_req  input  1  single-cycle pulse, clk domain: transmitter needs the next frame
- flush  input  1  synchronous FIFO clear
- mute  input  1  force zero samples on popped frames
- left_data  output  DW  held left sample to the transmitter
- right_data  output  DW  held right sample to the transmitter
- frame_valid  output  1  held frame came from the FIFO (0 = underrun fill)
- frame_src  output  1  source id of the held frame
- fifo_level  output  AW+1  frames currently stored
- underrun_cnt  output  16  saturating underrun counter

Behaviour:
- Reset (async): FIFO pointers and count = 0; left_data = right_data = 0; frame_valid = 0; frame_src = 0; underrun_cnt = 0; rr_last = 1, so s0 has priority first.
- full = (count == DEPTH), computed from the registered count. A same-cycle pop gives no credit: ready is low while full even if frame_req is high.
- Arbitration (combinational):
  - If not full and not flush: a single valid requester gets ready.
  - If both are valid, the requester other than rr_last gets ready.
  - At most one ready is high per cycle.
  - No valid requester means no grant and rr_last is unchanged.
- Push: valid & ready writes {src, left, right} at the write pointer; the write pointer increments modulo DEPTH; rr_last <= granted id.
- Pop on a frame_req cycle:
  - If count > 0: next edge loads left_data/right_data from the head (zeros if mute = 1), frame_valid <= 1, frame_src <= stored src; the read pointer increments.
  - If count == 0 (underrun): left_data = right_data = 0, frame_valid <= 0, frame_src unchanged, underrun_cnt increments and saturates at 16'hFFFF.
  - Pop latency: 1 clk from frame_req to the updated outputs.
- No bypass: a push into an empty FIFO in the same cycle as frame_req still produces an underrun. The pushed frame is stored and popped on the next request.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Outputs are held between frame_req pulses and change only on a pop or reset.
- flush: next edge sets pointers and count to 0. Ready is low in the flush cycle. A frame_req in that cycle is treated as an underrun. Held outputs and underrun_cnt are not cleared.
- mute affects only frames popped while it is high. The FIFO still drains normally.
- fifo_level = count, registered.
- Reset mid-operation drops all stored frames with no partial-frame state left.

Optional Feature:
- Macro: I2S_FRAME_ARB_HOLD_LAST_EN.
- Defined: on underrun, left_data/right_data keep the previous frame's values (repeat-last); frame_valid <= 0; underrun_cnt still increments.
- Undefined: underrun drives zeros as specified above.

Test Plan:
- s0 pushes L=16'h1234, R=16'hABCD, then one frame_req pulse -> next clk left_data=1234, right_data=ABCD, frame_valid=1, frame_src=0, fifo_level=0.
- s0 and s1 both continuously valid from reset, 4 cycles -> grants alternate s0,s1,s0,s1; fifo_level=4; both ready low on cycle 5.
- FIFO full plus frame_req in the same cycle -> no push that cycle, level 3; push resumes the next cycle.
- frame_req with empty FIFO, 3 times -> outputs zero, frame_valid=0, underrun_cnt=3. With the macro defined, outputs repeat the last frame instead.
- Fill 3 frames, assert flush, then frame_req -> fifo_level=0 and an underrun is counted. Separately, mute=1 on a pop of 16'h7FFF/16'h8000 -> outputs 0/0, frame_valid=1.
- Assert reset mid-stream with level=2 -> all outputs and counters return to reset values, and the first post-reset grant goes to s0.
